// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sub_pkg                                                   |
// | Brief    : State encoding and helpers for the bit-serial subtractor  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package sub_pkg;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  // busy covers the whole interval from acceptance to the done pulse
  function automatic logic busy_state(input logic [1:0] s);
    return (s == RUN) || (s == DONE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_half_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : half_subtractor                                           |
// | Brief    : One-bit half subtractor, d = x - y with borrow-out        |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);

  assign d  = x ^ y;
  assign bo = ~x & y;

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : serial_subtractor                                         |
// | Brief    : Bit-serial unsigned subtractor, LSB first, start/done     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  localparam int                 c_cnt_w    = $clog2(WIDTH + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_res;
  logic [WIDTH-1:0]   r_d;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_borrow;
  logic               r_bout;
  logic               r_busy;
  logic               r_done;

  logic             w_d0;
  logic             w_bo0;
  logic             w_diff;
  logic             w_bo1;
  logic             w_bnext;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  // Full-subtract cell: x - y first, then subtract the carried borrow
  half_subtractor u_hs0 (
    .x  (r_a[0]),
    .y  (r_b[0]),
    .d  (w_d0),
    .bo (w_bo0)
  );

  half_subtractor u_hs1 (
    .x  (w_d0),
    .y  (r_borrow),
    .d  (w_diff),
    .bo (w_bo1)
  );

  assign w_bnext    = w_bo0 | w_bo1;
  assign w_last     = (r_cnt == c_cnt_last);
  assign w_res_next = {w_diff, r_res[WIDTH-1:1]};

  always_comb begin
    w_state_next = IDLE;
    case (r_state)
      IDLE:    w_state_next = start ? RUN : IDLE;
      RUN:     w_state_next = w_last ? DONE : RUN;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_d      <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= busy_state(w_state_next);
      r_done  <= (w_state_next == DONE);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
          end
        end
        RUN: begin
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_res    <= w_res_next;
          r_borrow <= w_bnext;
          r_cnt    <= r_cnt + c_cnt_one;
          // Only the completed word is published; partial shifts stay internal
          if (w_last) begin
            r_d    <= w_res_next;
            r_bout <= w_bnext;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign d    = r_d;
  assign bout = r_bout;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_serial_subtractor                                      |
// | Brief    : Directed self-checking bench for serial_subtractor        |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;

  int n_cmp = 0;
  int n_err = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full operation: accept, wait for done (bounded), check result and return to idle
  task automatic do_op(input logic [7:0] op_a, input logic [7:0] op_b, input string tag);
    logic [7:0] exp_d;
    logic       exp_bo;
    int         lat;
    bit         seen;
    exp_d  = op_a - op_b;
    exp_bo = (op_a < op_b);
    a = op_a;
    b = op_b;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, ".busy_rise"}, 32'(busy), 32'd1);
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    check({tag, ".latency"}, 32'(lat), 32'd8);
    check({tag, ".d"}, 32'(d), 32'(exp_d));
    check({tag, ".bout"}, 32'(bout), 32'(exp_bo));
    tick();
    check({tag, ".busy_fall"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int n_done;
    logic [7:0] ra;
    logic [7:0] rb;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    check("reset.busy_done", {30'd0, busy, done}, 32'd0);
    check("reset.d_bout", {23'd0, d, bout}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic 100-58 with detailed timing
    a = 8'd100;
    b = 8'd58;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 7; k++) tick();
    check("basic.pre_done", {30'd0, busy, done}, 32'd2);
    check("basic.d_hidden", 32'(d), 32'd0);
    tick();
    check("basic.done", 32'(done), 32'd1);
    check("basic.d", 32'(d), 32'd42);
    check("basic.bout", 32'(bout), 32'd0);
    tick();
    check("basic.idle", {30'd0, busy, done}, 32'd0);
    check("basic.d_hold", 32'(d), 32'd42);

    do_op(8'h05, 8'h07, "borrow1");
    do_op(8'h00, 8'h01, "borrow_ripple");
    do_op(8'hFF, 8'hFF, "equal");
    do_op(8'hFF, 8'h00, "max_minus_zero");

    // start re-pulsed mid-run must not disturb the operation
    a = 8'd200;
    b = 8'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 8'd1;
    b = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_done = 0;
    for (int k = 4; k <= 14; k++) begin
      tick();
      if (done) begin
        n_done++;
        check("repulse.d", 32'(d), 32'd190);
        check("repulse.bout", 32'(bout), 32'd0);
      end
    end
    check("repulse.done_count", 32'(n_done), 32'd1);
    check("repulse.idle", 32'(busy), 32'd0);

    // start held high across done: second op accepted at edge 10
    a = 8'd200;
    b = 8'd10;
    start = 1'b1;
    tick();
    a = 8'd50;
    b = 8'd20;
    for (int k = 1; k <= 8; k++) tick();
    check("held.first_done", 32'(done), 32'd1);
    check("held.first_d", 32'(d), 32'd190);
    tick();
    check("held.gap_idle", 32'(busy), 32'd0);
    tick();
    check("held.second_accept", 32'(busy), 32'd1);
    start = 1'b0;
    for (int k = 11; k <= 17; k++) tick();
    check("held.d_hold", 32'(d), 32'd190);
    check("held.no_early_done", 32'(done), 32'd0);
    tick();
    check("held.second_done", 32'(done), 32'd1);
    check("held.second_d", 32'(d), 32'd30);
    tick();

    // Asynchronous reset mid-run, asserted between edges
    a = 8'd77;
    b = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("areset.busy_done", {30'd0, busy, done}, 32'd0);
    check("areset.d_bout", {23'd0, d, bout}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    do_op(8'd9, 8'd4, "after_reset");

    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      do_op(ra, rb, "rand");
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
